// File: rtl/d_ff.sv
// d_ff: parameterised D-type register, a pipeline of DEPTH flops per bit with
// synchronous active-high reset. Generic staging / retiming primitive.
//
// Parameters:
//   WIDTH    data width of D/Q (>= 1)
//   DEPTH    number of register stages between D and Q (>= 1); latency in edges
//   RST_VAL  value loaded into every stage on reset
//
// Ports (positional order Q, D, Clk, rst[, Qn]):
//   Q    output WIDTH  data out, taken straight from the last stage flop
//   D    input  WIDTH  data in, sampled on rising Clk
//   Clk  input  1      clock, rising edge only
//   rst  input  1      synchronous reset, active-high, priority over D
//   Qn   output WIDTH  complement of Q; present only when D_FF_QN_EN is defined
//
// Optional feature macro: D_FF_QN_EN (adds the Qn output, reset value ~RST_VAL).

module d_ff #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             Clk,
    input  logic             rst
`ifdef D_FF_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    // Reject degenerate configurations at elaboration time.
    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_cfg
        $error("d_ff: WIDTH and DEPTH must both be >= 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift pipeline; reset flushes every stage to RST_VAL.
    always_ff @(posedge Clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= D;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign Q = stage_q[DEPTH-1];

`ifdef D_FF_QN_EN
    // Value about to enter the last stage, so Qn can be its own flop with no
    // inverter hanging off Q and no added latency.
    logic [WIDTH-1:0] last_d;

    if (DEPTH == 1) begin : g_last_from_d
        assign last_d = D;
    end else begin : g_last_from_stage
        assign last_d = stage_q[DEPTH-2];
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            Qn <= ~RST_VAL;
        end else begin
            Qn <= ~last_d;
        end
    end
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed self-checking bench for d_ff: a default single-bit instance and a
// WIDTH=8 / DEPTH=3 / RST_VAL=8'hA5 pipeline instance share one clock.

module tb_d_ff;

    logic       clk;
    logic       rst;
    logic       d;
    logic       q;
    logic       rst_w;
    logic [7:0] d_w;
    logic [7:0] q_w;
`ifdef D_FF_QN_EN
    logic       qn;
    logic [7:0] qn_w;
`endif

    int n_cmp;
    int n_bad;

    d_ff u_bit (
        .Q   (q),
        .D   (d),
        .Clk (clk),
        .rst (rst)
`ifdef D_FF_QN_EN
        ,
        .Qn  (qn)
`endif
    );

    d_ff #(
        .WIDTH   (8),
        .DEPTH   (3),
        .RST_VAL (8'hA5)
    ) u_pipe (
        .Q   (q_w),
        .D   (d_w),
        .Clk (clk),
        .rst (rst_w)
`ifdef D_FF_QN_EN
        ,
        .Qn  (qn_w)
`endif
    );

    // Rising edges at t = 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst   = 1'b1;
        d     = 1'b1;
        rst_w = 1'b1;
        d_w   = 8'hFF;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_beats_data: q=%b expected 0", q);
        end
        n_cmp++;
        if (q_w !== 8'hA5) begin
            n_bad++;
            $display("FAIL pipe_reset_value: q_w=%h expected a5", q_w);
        end
`ifdef D_FF_QN_EN
        n_cmp++;
        if (qn !== 1'b1) begin
            n_bad++;
            $display("FAIL qn_reset: qn=%b expected 1", qn);
        end
        n_cmp++;
        if (qn_w !== 8'h5A) begin
            n_bad++;
            $display("FAIL pipe_qn_reset: qn_w=%h expected 5a", qn_w);
        end
`endif
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b1) begin
            n_bad++;
            $display("FAIL capture_one: q=%b expected 1", q);
        end
`ifdef D_FF_QN_EN
        n_cmp++;
        if (qn !== 1'b0) begin
            n_bad++;
            $display("FAIL qn_after_one: qn=%b expected 0", qn);
        end
`endif
        @(negedge clk);
        d = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b0) begin
            n_bad++;
            $display("FAIL capture_zero: q=%b expected 0", q);
        end
    endtask

    task automatic test_between_edges();
        // High pulse wholly between edges must be ignored.
        @(negedge clk);
        d = 1'b0;
        #1 d = 1'b1;
        #2 d = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_high_pulse: q=%b expected 0", q);
        end
        @(negedge clk);
        d = 1'b1;
        @(posedge clk); #1;
        // Low pulse between edges must be ignored as well.
        #2 d = 1'b0;
        #2 d = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_low_pulse: q=%b expected 1", q);
        end
    endtask

    task automatic test_mid_reset();
        // q is 1 with d held at 1; raise rst between edges.
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (q !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_waits_for_edge: q=%b expected 1", q);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_stream: q=%b expected 0", q);
        end
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 1'b1) begin
            n_bad++;
            $display("FAIL after_rst_release: q=%b expected 1", q);
        end
    endtask

    task automatic test_pipeline_latency();
        logic [7:0] exp_q [3];
        exp_q = '{8'hA5, 8'hA5, 8'h3C};
        @(negedge clk);
        rst_w = 1'b0;
        d_w   = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) d_w = 8'h00;
            n_cmp++;
            if (q_w !== exp_q[i]) begin
                n_bad++;
                $display("FAIL pipe_latency edge+%0d: q_w=%h expected %h", i, q_w, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] din   [7];
        logic [7:0] exp_q [7];
        din   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00};
        exp_q = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        @(negedge clk);
        rst_w = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst_w = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d_w = din[i];
            @(posedge clk); #1;
            n_cmp++;
            if (q_w !== exp_q[i]) begin
                n_bad++;
                $display("FAIL back_to_back step %0d: q_w=%h expected %h", i, q_w, exp_q[i]);
            end
`ifdef D_FF_QN_EN
            n_cmp++;
            if (qn_w !== ~exp_q[i]) begin
                n_bad++;
                $display("FAIL pipe_qn step %0d: qn_w=%h expected %h", i, qn_w, ~exp_q[i]);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_q [4];
        exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'h77};
        // Fill the pipe with live data, then reset for one edge.
        rst_w = 1'b0;
        d_w   = 8'hC1;
        @(posedge clk); #1;
        @(negedge clk);
        d_w = 8'hC2;
        @(posedge clk); #1;
        @(negedge clk);
        rst_w = 1'b1;
        d_w   = 8'hC3;
        @(posedge clk); #1;
        n_cmp++;
        if (q_w !== exp_q[0]) begin
            n_bad++;
            $display("FAIL flush_reset: q_w=%h expected %h", q_w, exp_q[0]);
        end
        @(negedge clk);
        rst_w = 1'b0;
        d_w   = 8'h77;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) d_w = 8'h00;
            n_cmp++;
            if (q_w !== exp_q[i]) begin
                n_bad++;
                $display("FAIL flush_refill edge+%0d: q_w=%h expected %h", i - 1, q_w, exp_q[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        d     = 1'b0;
        rst_w = 1'b1;
        d_w   = 8'h00;
        test_reset();
        test_capture();
        test_between_edges();
        test_mid_reset();
        test_pipeline_latency();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
